// File: rtl/trace_arb_pkg.sv
// rtl/trace_arb_pkg.sv - state encoding and character constants shared by trace_arbiter
package trace_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [7:0] CH_START = 8'h5E;
   localparam logic [7:0] CH_END   = 8'h23;
   localparam logic [7:0] CH_LF    = 8'h0A;

   localparam int NSRC = 2;

endpackage

// File: rtl/trace_arb_rr.sv
// rtl/trace_arb_rr.sv - two-way round-robin pick between record-start candidates
module trace_arb_rr
   import trace_arb_pkg::*;
(
   input  logic [NSRC-1:0] cand,
   input  logic            rr,
   output logic            win
);

   // Contention goes to the pointer; otherwise the lone candidate wins (0 when none).
   assign win = (cand == 2'b11) ? rr : cand[1];

endmodule

// File: rtl/trace_arbiter.sv
// rtl/trace_arbiter.sv - grants one of two character sources a whole '^'..'#' trace record
// Optional record timeout and abort when built with TRACE_ARB_TIMEOUT_EN.
module trace_arbiter
   import trace_arb_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NSRC-1:0]  in_valid,
   input  logic [7:0]       in_char0,
   input  logic [7:0]       in_char1,
   output logic [NSRC-1:0]  in_ready,
   output logic             out_valid,
   output logic [7:0]       out_char,
   output logic             out_src,
   input  logic [1:0]       fmt_in,
   output logic             rec_done,
   output logic             abort,
   output logic [CNT_W-1:0] good_cnt0,
   output logic [CNT_W-1:0] good_cnt1
);

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("trace_arbiter: TIMEOUT must be within 2..255");
   end

   state_t           state_q, state_d;
   logic             g_q, g_d;
   logic             rr_q, rr_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_char_q, out_char_d;
   logic             out_src_q, out_src_d;
   logic             rec_done_q, rec_done_d;
   logic [CNT_W-1:0] good_cnt0_q, good_cnt0_d;
   logic [CNT_W-1:0] good_cnt1_q, good_cnt1_d;
   // Stage 1 of the tag pipeline lines up with the cycle the checker result is valid.
   logic [1:0]       tag_vld_q, tag_vld_d;
   logic [1:0]       tag_src_q, tag_src_d;

   logic [NSRC-1:0]  cand;
   logic             win;
   logic [NSRC-1:0]  rdy;
   logic [7:0]       g_char;

`ifdef TRACE_ARB_TIMEOUT_EN
   logic [7:0]       tmo_cnt_q, tmo_cnt_d;
   logic             abort_q, abort_d;
   assign abort = abort_q;
`else
   assign abort = 1'b0;
`endif

   assign cand[0] = in_valid[0] && (in_char0 == CH_START);
   assign cand[1] = in_valid[1] && (in_char1 == CH_START);
   assign g_char  = g_q ? in_char1 : in_char0;

   trace_arb_rr u_rr (
      .cand (cand),
      .rr   (rr_q),
      .win  (win)
   );

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      rr_d        = rr_q;
      out_valid_d = 1'b0;
      out_char_d  = out_char_q;
      out_src_d   = out_src_q;
      rec_done_d  = 1'b0;
      good_cnt0_d = good_cnt0_q;
      good_cnt1_d = good_cnt1_q;
      tag_vld_d   = {tag_vld_q[0], 1'b0};
      tag_src_d   = {tag_src_q[0], tag_src_q[0]};
      rdy         = '0;
`ifdef TRACE_ARB_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      abort_d     = 1'b0;
`endif

      if (tag_vld_q[1] && (fmt_in != 2'b00)) begin
         if (!tag_src_q[1] && (good_cnt0_q != '1)) good_cnt0_d = good_cnt0_q + CNT_W'(1);
         if ( tag_src_q[1] && (good_cnt1_q != '1)) good_cnt1_d = good_cnt1_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            // Everything except the losing '^' is taken; non-start characters are dropped.
            rdy[0] = !(cand[0] &&  win);
            rdy[1] = !(cand[1] && !win);
`ifdef TRACE_ARB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
            if (cand != '0) begin
               out_valid_d = 1'b1;
               out_char_d  = CH_START;
               out_src_d   = win;
               g_d         = win;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            rdy[g_q] = 1'b1;
            if (in_valid[g_q]) begin
               out_valid_d = 1'b1;
               out_char_d  = g_char;
               out_src_d   = g_q;
`ifdef TRACE_ARB_TIMEOUT_EN
               tmo_cnt_d   = '0;
`endif
               if (g_char == CH_END) begin
                  rec_done_d   = 1'b1;
                  state_d      = IDLE;
                  rr_d         = ~g_q;
                  tag_vld_d[0] = 1'b1;
                  tag_src_d[0] = g_q;
               end
            end
`ifdef TRACE_ARB_TIMEOUT_EN
            else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
               // Line feed lets the checker drop the partial record and resynchronise.
               abort_d     = 1'b1;
               out_valid_d = 1'b1;
               out_char_d  = CH_LF;
               out_src_d   = g_q;
               state_d     = IDLE;
               rr_d        = ~g_q;
               tmo_cnt_d   = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      in_ready = reset ? rdy : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         g_q         <= 1'b0;
         rr_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_char_q  <= 8'h00;
         out_src_q   <= 1'b0;
         rec_done_q  <= 1'b0;
         good_cnt0_q <= '0;
         good_cnt1_q <= '0;
         tag_vld_q   <= '0;
         tag_src_q   <= '0;
`ifdef TRACE_ARB_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         abort_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         rr_q        <= rr_d;
         out_valid_q <= out_valid_d;
         out_char_q  <= out_char_d;
         out_src_q   <= out_src_d;
         rec_done_q  <= rec_done_d;
         good_cnt0_q <= good_cnt0_d;
         good_cnt1_q <= good_cnt1_d;
         tag_vld_q   <= tag_vld_d;
         tag_src_q   <= tag_src_d;
`ifdef TRACE_ARB_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         abort_q     <= abort_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_char  = out_char_q;
   assign out_src   = out_src_q;
   assign rec_done  = rec_done_q;
   assign good_cnt0 = good_cnt0_q;
   assign good_cnt1 = good_cnt1_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// tb/tb_trace_arbiter.sv - self-checking bench for trace_arbiter (default and TRACE_ARB_TIMEOUT_EN builds)
module tb_trace_arbiter;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 8;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       in_valid;
   logic [7:0]       in_char0, in_char1;
   logic [1:0]       in_ready;
   logic             out_valid;
   logic [7:0]       out_char;
   logic             out_src;
   logic [1:0]       fmt;
   logic             rec_done;
   logic             abort;
   logic [CNT_W-1:0] good_cnt0, good_cnt1;

   trace_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_valid  (in_valid),
      .in_char0  (in_char0),
      .in_char1  (in_char1),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_char  (out_char),
      .out_src   (out_src),
      .fmt_in    (fmt),
      .rec_done  (rec_done),
      .abort     (abort),
      .good_cnt0 (good_cnt0),
      .good_cnt1 (good_cnt1)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: record-level rules with a due-cycle list for checker samples.
   typedef struct {
      int due;
      bit src;
   } pend_t;

   pend_t      pend[$];
   bit         m_busy = 0, m_g = 0, m_rr = 0;
   int         m_idle = 0, m_cnt0 = 0, m_cnt1 = 0, cyc = 0;
   bit         e_ov = 0, e_rd = 0, e_ab = 0, e_src = 0;
   logic [7:0] e_ch = 8'h00;

   function automatic logic [1:0] f_ready();
      bit c0, c1;
      if (!rst_n) return 2'b00;
      if (m_busy) return m_g ? 2'b10 : 2'b01;
      c0 = in_valid[0] && in_char0 == "^";
      c1 = in_valid[1] && in_char1 == "^";
      if (c0 && c1) return m_rr ? 2'b10 : 2'b01;
      return 2'b11;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_g = 0; m_rr = 0; m_idle = 0; m_cnt0 = 0; m_cnt1 = 0;
      pend.delete();
      e_ov = 0; e_rd = 0; e_ab = 0; e_src = 0; e_ch = 8'h00;
   endtask

   task automatic model_edge();
      logic [7:0] ch;
      bit c0, c1, w;
      int k;
      e_ov = 0; e_rd = 0; e_ab = 0;
      k = 0;
      while (k < pend.size()) begin
         if (pend[k].due == cyc) begin
            if (fmt != 2'b00) begin
               if (pend[k].src) m_cnt1 = (m_cnt1 < CMAX) ? m_cnt1 + 1 : CMAX;
               else             m_cnt0 = (m_cnt0 < CMAX) ? m_cnt0 + 1 : CMAX;
            end
            pend.delete(k);
         end else begin
            k++;
         end
      end
      if (!m_busy) begin
         c0 = in_valid[0] && in_char0 == "^";
         c1 = in_valid[1] && in_char1 == "^";
         if (c0 || c1) begin
            w = (c0 && c1) ? m_rr : c1;
            e_ov = 1; e_ch = "^"; e_src = w;
            m_busy = 1; m_g = w; m_idle = 0;
         end
      end else if (in_valid[m_g]) begin
         ch = m_g ? in_char1 : in_char0;
         e_ov = 1; e_ch = ch; e_src = m_g; m_idle = 0;
         if (ch == "#") begin
            e_rd = 1; m_busy = 0; m_rr = !m_g;
            pend.push_back('{cyc + 2, m_g});
         end
      end else begin
`ifdef TRACE_ARB_TIMEOUT_EN
         m_idle++;
         if (m_idle == TIMEOUT) begin
            e_ab = 1; e_ov = 1; e_ch = 8'h0A; e_src = m_g;
            m_busy = 0; m_rr = !m_g; m_idle = 0;
         end
`endif
      end
      cyc++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_edge();
   end

   logic [8:0] cap[$];
   int         n_rd = 0, n_abort = 0, n_lf = 0;

   always @(negedge clk) begin
      logic [1:0] er, mask;
      er   = f_ready();
      mask = (!rst_n || m_busy) ? 2'b11 : in_valid;
      chk("in_ready", 32'(in_ready & mask), 32'(er & mask));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      if (e_ov) begin
         chk("out_char", 32'(out_char), 32'(e_ch));
         chk("out_src", 32'(out_src), 32'(e_src));
      end
      chk("rec_done", 32'(rec_done), 32'(e_rd));
      chk("abort", 32'(abort), 32'(e_ab));
      chk("good_cnt0", 32'(good_cnt0), 32'(m_cnt0));
      chk("good_cnt1", 32'(good_cnt1), 32'(m_cnt1));
      if (out_valid) cap.push_back({out_src, out_char});
      if (rec_done) n_rd++;
      if (abort) n_abort++;
      if (out_valid && out_char == 8'h0A) n_lf++;
   end

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   function automatic void push_str(input string s, input bit src);
      for (int i = 0; i < s.len(); i++) begin
         if (src) q1.push_back(s[i]);
         else     q0.push_back(s[i]);
      end
   endfunction

   // Presents queued characters, popping each one the DUT accepts.
   task automatic run(input int budget);
      int n;
      logic [1:0] rdy;
      logic [7:0] tmp;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
         in_valid = {q1.size() > 0, q0.size() > 0};
         in_char0 = (q0.size() > 0) ? q0[0] : 8'h00;
         in_char1 = (q1.size() > 0) ? q1[0] : 8'h00;
         #1;
         rdy = in_ready;
         @(posedge clk); #2;
         if (rdy[0] && in_valid[0]) tmp = q0.pop_front();
         if (rdy[1] && in_valid[1]) tmp = q1.pop_front();
         n++;
      end
      in_valid = 2'b00;
      chk("run_drained", 32'(q0.size() + q1.size()), 32'd0);
      q0.delete();
      q1.delete();
   endtask

   task automatic idle(input int n);
      in_valid = 2'b00;
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) begin
         @(posedge clk); #2;
      end
      rst_n = 1'b1;
   endtask

   task automatic chk_cap(input string name, input string s, input bit src, input int start);
      int bad;
      bad = 0;
      for (int i = 0; i < s.len(); i++) begin
         if (start + i >= cap.size()) bad++;
         else if (cap[start + i] !== {src, s[i]}) bad++;
      end
      chk(name, 32'(bad), 32'd0);
   endtask

   string rec1 = "^10@00003000: $ 1 <= 00000001#";

   initial begin
      rst_n = 1'b1; in_valid = 2'b00; in_char0 = 8'h00; in_char1 = 8'h00; fmt = 2'b00;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_char", 32'(out_char), 32'h00);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_good_cnt0", 32'(good_cnt0), 32'd0);
      rst_n = 1'b1;

      // Single record from source 0
      fmt = 2'b01; cap.delete(); n_rd = 0;
      push_str(rec1, 0);
      run(100); idle(3);
      chk("t1_len", 32'(cap.size()), 32'd30);
      chk_cap("t1_chars", rec1, 0, 0);
      chk("t1_rec_done_pulses", 32'(n_rd), 32'd1);
      chk("t1_good_cnt0", 32'(good_cnt0), 32'd1);

      // Simultaneous '^' after reset: source 0 first, then source 1
      do_reset();
      fmt = 2'b00; cap.delete();
      push_str("^a#", 0); push_str("^a#", 1);
      run(50); idle(3);
      chk("t2_len", 32'(cap.size()), 32'd6);
      chk_cap("t2_src0", "^a#", 0, 0);
      chk_cap("t2_src1", "^a#", 1, 3);

      // Leading junk dropped in IDLE
      cap.delete();
      push_str("ab^cd#", 1);
      run(50); idle(3);
      chk("t3_len", 32'(cap.size()), 32'd4);
      chk_cap("t3_chars", "^cd#", 1, 0);

      // Stalled record
      cap.delete(); n_abort = 0; n_lf = 0; fmt = 2'b11;
      push_str("^12@", 0);
      run(50); idle(8);
      push_str("3#", 0);
      run(50); idle(3);
`ifdef TRACE_ARB_TIMEOUT_EN
      chk("t4_len", 32'(cap.size()), 32'd5);
      chk_cap("t4_chars", "^12@\n", 0, 0);
      chk("t4_aborts", 32'(n_abort), 32'd1);
      chk("t4_lf_count", 32'(n_lf), 32'd1);
      chk("t4_good_cnt0", 32'(good_cnt0), 32'd0);
`else
      chk("t4_len", 32'(cap.size()), 32'd6);
      chk_cap("t4_chars", "^12@3#", 0, 0);
      chk("t4_aborts", 32'(n_abort), 32'd0);
      chk("t4_good_cnt0", 32'(good_cnt0), 32'd1);
`endif

      // Saturation over 256 back-to-back records
      fmt = 2'b10;
      for (int i = 0; i < 256; i++) push_str("^#", 0);
      run(1200); idle(3);
      chk("t5_good_cnt0_sat", 32'(good_cnt0), 32'd255);
      chk("t5_good_cnt1", 32'(good_cnt1), 32'd0);

      // Reset right after '#': outputs clear at once and the pending sample is lost
      fmt = 2'b01;
      push_str("^ab#", 0);
      run(50);
      rst_n = 1'b0;
      #1;
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_out_char", 32'(out_char), 32'h00);
      chk("t6_rec_done", 32'(rec_done), 32'd0);
      chk("t6_in_ready", 32'(in_ready), 32'd0);
      chk("t6_good_cnt0", 32'(good_cnt0), 32'd0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      rst_n = 1'b1;
      cap.delete();
      push_str("^z#", 1);
      run(50); idle(3);
      chk_cap("t6_after_release", "^z#", 1, 0);
      chk("t6_good_cnt0_final", 32'(good_cnt0), 32'd0);
      chk("t6_good_cnt1_final", 32'(good_cnt1), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/trace_arbiter.md
TRACE_ARBITER -- requirements
Module: trace_arbiter

Interface
REQ-001 Parameter TIMEOUT, 64: BUSY-state idle cycles before record abort; legal range 2..255.
REQ-002 Parameter CNT_W, 8: width of each good-record counter.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port in_valid  input  2: per-source character valid, bit i is source i.
REQ-006 Port in_char0 / in_char1  input  8: ASCII character from source 0 / 1.
REQ-007 Port in_ready  output  2: per-source accept; a character transfers when in_valid[i] and in_ready[i] are both high at an edge.
REQ-008 Port out_valid  output  1: registered character strobe to the shared trace checker.
REQ-009 Port out_char  output  8: registered character to the checker.
REQ-010 Port out_src  output  1: source index of out_char.
REQ-011 Port fmt_in  input  2: checker format result; 00 means invalid, otherwise valid.
REQ-012 Port rec_done  output  1: one-cycle pulse when a granted record ends with '#'.
REQ-013 Port abort  output  1: one-cycle pulse on record timeout.
REQ-014 Port good_cnt0 / good_cnt1  output  CNT_W: saturating count of checker-accepted records per source.

Function
REQ-015 FSM states SHALL be IDLE and BUSY, with a 1-bit grant register g and a 1-bit round-robin pointer rr.
REQ-016 In IDLE, a source is a candidate when its in_valid is high and its char is '^' (8'h5E).
- If both sources are candidates, source rr wins.
- The winner SHALL get in_ready=1; its '^' appears on out_char with out_valid=1 the next cycle; state goes to BUSY and g takes the winner.
- The loser SHALL get in_ready=0 and hold its character.
REQ-017 In IDLE, a valid non-'^' character SHALL be accepted (in_ready=1) and dropped, with no output.
REQ-018 In BUSY, in_ready[g] SHALL be 1 and in_ready[~g] SHALL be 0.
- Each accepted character SHALL be forwarded with 1-cycle latency, out_src=g.
- '^' mid-record SHALL be forwarded unchanged.
REQ-019 In BUSY, on accepting '#' (8'h23): forward it, pulse rec_done with out_valid, set state to IDLE and rr to ~g.
REQ-020 out_valid SHALL be 0 in every cycle following an edge with no forwarded character.
REQ-021 fmt_in SHALL be sampled exactly 2 cycles after the edge that accepted '#'.
- Sampled value nonzero: good_cnt[src of that record] increments, saturating at all-ones.
- A 2-stage tag pipeline carries the source index.
REQ-022 Records may be back to back.
- A new '^' may be accepted in the first IDLE cycle after '#'.
- Overlapping fmt_in samples SHALL be tracked independently.

Reset
REQ-023 While reset=0, the block SHALL hold the following values: state IDLE, g=0, rr=0, in_ready=0, out_valid=0, out_char=8'h00, out_src=0, rec_done=0, abort=0, good_cnt0=0, good_cnt1=0, timeout counter=0, tag pipeline cleared.
REQ-024 Reset asserted mid-record SHALL discard the record.
- No pending fmt_in sample survives.
- The first cycle after release is IDLE.

Configuration
REQ-025 Macro TRACE_ARB_TIMEOUT_EN defined enables the timeout behaviour.
- In BUSY, a counter counts consecutive cycles with in_valid[g]=0 and clears on any accepted character.
- When the count reaches TIMEOUT: pulse abort; emit out_char=8'h0A with out_valid=1 next cycle so the checker resynchronises; state goes to IDLE and rr to ~g.
- No fmt_in sample is taken for an aborted record.
REQ-026 Without TRACE_ARB_TIMEOUT_EN, the counter and abort logic are absent, abort is tied 0, and BUSY waits indefinitely for '#'.

Structure
REQ-027 Package trace_arb_pkg SHALL hold the following:
- state encoding, IDLE=1'b0 and BUSY=1'b1
- character constants CH_START='^', CH_END='#', CH_LF=8'h0A
- NSRC=2
REQ-028 One sub-module, trace_arb_rr, SHALL implement the 2-way round-robin pick (inputs: candidates, rr; output: winner).
- All FSM, counters and output registers stay in trace_arbiter.

Verification
REQ-029 Source 0 sends "^10@00003000: $ 1 <= 00000001#" while source 1 is idle.
- Required: all 30 characters appear in order on out_char, each one cycle after acceptance, with out_src=0.
- Required: rec_done pulses once; fmt_in=01 sampled 2 cycles later gives good_cnt0=1.
REQ-030 Both sources present '^' in the same IDLE cycle after reset (rr=0).
- Required: source 0 is granted and in_ready=2'b01 throughout the record.
- Required: after its '#', source 1 is granted on the next IDLE cycle.
REQ-031 In IDLE, source 1 sends "ab^", then its record.
- Required: 'a' and 'b' are consumed with out_valid=0.
- Required: forwarding starts at '^'.
REQ-032 With TRACE_ARB_TIMEOUT_EN and TIMEOUT=4, source 0 sends "^12@" then stalls.
- Required: abort pulses after 4 idle cycles; out_char=8'h0A is emitted once; state returns to IDLE.
- Required: good_cnt0 is unchanged.
REQ-033 Source 0 sends 256 valid records with fmt_in=10 and CNT_W=8.
- Required: good_cnt0 saturates at 255.
- Required: reset=0 asserted mid-record clears all outputs immediately.
